// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and valid/ready handshake.
// Optional stall counter output is enabled with `define ID_EX_STALL_CNT_EN.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_use_imm,
    input  logic [3:0]         id_alu_ctrl,
    input  logic [3:0]         id_shamt,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_reg_write,
    input  logic               flush,
    input  logic [RADDR_W-1:0] exm_rd_addr,
    input  logic               exm_reg_write,
    input  logic [XLEN-1:0]    exm_result,
    input  logic [RADDR_W-1:0] mwb_rd_addr,
    input  logic               mwb_reg_write,
    input  logic [XLEN-1:0]    mwb_result,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    alu_op1,
    output logic [XLEN-1:0]    alu_op2,
    output logic [3:0]         alu_ctrl,
    output logic [3:0]         alu_n,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_div_zero
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    logic               valid_q, valid_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic               use_imm_q, use_imm_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [3:0]         shamt_q, shamt_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               reg_write_q, reg_write_d;

    logic [XLEN-1:0]    fwd1, fwd2;
    logic               take_in, take_out, hold;

    // Handshake contract: a beat moves whenever valid and ready are both high
    // on a rising edge; ready never depends on valid from the same side.
    assign id_ready = !valid_q || ex_ready;
    assign take_in  = id_valid && id_ready;
    assign take_out = valid_q && ex_ready;
    assign hold     = valid_q && !ex_ready;

    // EX/MEM wins over MEM/WB; x0 is hardwired and never forwarded.
    always_comb begin
        fwd1 = rs1_data_q;
        if (rs1_addr_q != '0 && exm_reg_write && exm_rd_addr == rs1_addr_q)
            fwd1 = exm_result;
        else if (rs1_addr_q != '0 && mwb_reg_write && mwb_rd_addr == rs1_addr_q)
            fwd1 = mwb_result;
    end

    always_comb begin
        fwd2 = rs2_data_q;
        if (rs2_addr_q != '0 && exm_reg_write && exm_rd_addr == rs2_addr_q)
            fwd2 = exm_result;
        else if (rs2_addr_q != '0 && mwb_reg_write && mwb_rd_addr == rs2_addr_q)
            fwd2 = mwb_result;
    end

    always_comb begin
        valid_d     = valid_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        ctrl_d      = ctrl_q;
        shamt_d     = shamt_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (take_in) begin
            valid_d     = 1'b1;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            ctrl_d      = id_alu_ctrl;
            shamt_d     = id_shamt;
            rd_d        = id_rd_addr;
            reg_write_d = id_reg_write;
        end else begin
            if (take_out)
                valid_d = 1'b0;
            // Capture forwarded values while stalled so a retiring producer is not lost.
            if (hold) begin
                rs1_data_d = fwd1;
                rs2_data_d = fwd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            ctrl_q      <= 4'd0;
            shamt_q     <= 4'd0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            ctrl_q      <= ctrl_d;
            shamt_q     <= shamt_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_op1      = fwd1;
    assign alu_op2      = use_imm_q ? imm_q : fwd2;
    assign alu_ctrl     = ctrl_q;
    assign alu_n        = shamt_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = reg_write_q && valid_q;
    // 0011 and 1111 are the divide/modulo encodings.
    assign ex_div_zero  = valid_q && (ctrl_q == 4'b0011 || ctrl_q == 4'b1111) && (alu_op2 == '0);

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage; define ID_EX_STALL_CNT_EN to also cover the stall counter.
module tb_id_ex_operand_stage;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int VW      = 2*XLEN + 4 + 4 + RADDR_W + 1;

    logic               clk;
    logic               rst;
    logic               id_valid;
    logic               id_ready;
    logic [RADDR_W-1:0] id_rs1_addr, id_rs2_addr;
    logic [XLEN-1:0]    id_rs1_data, id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic               id_use_imm;
    logic [3:0]         id_alu_ctrl;
    logic [3:0]         id_shamt;
    logic [RADDR_W-1:0] id_rd_addr;
    logic               id_reg_write;
    logic               flush;
    logic [RADDR_W-1:0] exm_rd_addr;
    logic               exm_reg_write;
    logic [XLEN-1:0]    exm_result;
    logic [RADDR_W-1:0] mwb_rd_addr;
    logic               mwb_reg_write;
    logic [XLEN-1:0]    mwb_result;
    logic               ex_ready;
    logic               ex_valid;
    logic [XLEN-1:0]    alu_op1, alu_op2;
    logic [3:0]         alu_ctrl;
    logic [3:0]         alu_n;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_reg_write;
    logic               ex_div_zero;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0]        stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_v;
    logic [VW-1:0] got_v;

    assign got_v = {alu_op1, alu_op2, alu_ctrl, alu_n, ex_rd_addr, ex_reg_write};

    id_ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_shamt(id_shamt),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .flush(flush),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd_addr(mwb_rd_addr), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_ctrl(alu_ctrl), .alu_n(alu_n),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_div_zero(ex_div_zero)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: sim time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] exp_vec(input logic [XLEN-1:0] o1, input logic [XLEN-1:0] o2,
                                              input logic [3:0] c, input logic [3:0] nn,
                                              input logic [RADDR_W-1:0] rd, input logic rw);
        return {o1, o2, c, nn, rd, rw};
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid      = 1'b0;
        id_rs1_addr   = '0;
        id_rs2_addr   = '0;
        id_rs1_data   = '0;
        id_rs2_data   = '0;
        id_imm        = '0;
        id_use_imm    = 1'b0;
        id_alu_ctrl   = 4'd0;
        id_shamt      = 4'd0;
        id_rd_addr    = '0;
        id_reg_write  = 1'b0;
        flush         = 1'b0;
        exm_rd_addr   = '0;
        exm_reg_write = 1'b0;
        exm_result    = '0;
        mwb_rd_addr   = '0;
        mwb_reg_write = 1'b0;
        mwb_result    = '0;
    endtask

    task automatic offer(input logic [RADDR_W-1:0] a1, input logic [RADDR_W-1:0] a2,
                         input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] imm, input logic ui,
                         input logic [3:0] c, input logic [3:0] nn,
                         input logic [RADDR_W-1:0] rd, input logic rw);
        id_valid     = 1'b1;
        id_rs1_addr  = a1;
        id_rs2_addr  = a2;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_use_imm   = ui;
        id_alu_ctrl  = c;
        id_shamt     = nn;
        id_rd_addr   = rd;
        id_reg_write = rw;
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        ex_ready = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
        n_vec++;
        if (got_v !== {VW{1'b0}}) begin n_err++; $display("FAIL reset_fields got %h exp 0", got_v); end
        n_vec++;
        if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_id_ready got %b exp 1", id_ready); end
        n_vec++;
        if (ex_div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero got %b exp 0", ex_div_zero); end
`ifdef ID_EX_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        ex_ready = 1'b1;
        offer(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0000, 4'd3, 5'd4, 1'b1);
        exp_q.push_back(exp_vec(32'd5, 32'd7, 4'b0000, 4'd3, 5'd4, 1'b1));
        step();
        id_valid = 1'b0;
        #1;
        n_vec++;
        if (ex_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", ex_valid); end
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL basic_fields got %h exp %h", got_v, exp_v); end
        step();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_err++; $display("FAIL basic_drain got valid=%b rw=%b exp 0/0", ex_valid, ex_reg_write);
        end
    endtask

    task automatic test_forward();
        ex_ready = 1'b1;
        offer(5'd3, 5'd0, 32'hAA, 32'h33, 32'd0, 1'b0, 4'b0001, 4'd2, 5'd7, 1'b1);
        step();
        id_valid = 1'b0;
        exm_rd_addr = 5'd3; exm_reg_write = 1'b1; exm_result = 32'h11;
        mwb_rd_addr = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'h22;
        exp_q.push_back(exp_vec(32'h11, 32'h33, 4'b0001, 4'd2, 5'd7, 1'b1));
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL fwd_exm_priority got %h exp %h", got_v, exp_v); end
        exm_reg_write = 1'b0;
        exp_q.push_back(exp_vec(32'h22, 32'h33, 4'b0001, 4'd2, 5'd7, 1'b1));
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL fwd_mwb got %h exp %h", got_v, exp_v); end
        // Source x0 must ignore forwarding even when producers target x0.
        offer(5'd0, 5'd5, 32'hAA, 32'hBB, 32'd0, 1'b0, 4'b0010, 4'd1, 5'd9, 1'b0);
        step();
        id_valid = 1'b0;
        exm_rd_addr = 5'd0; exm_reg_write = 1'b1; exm_result = 32'h11;
        mwb_rd_addr = 5'd0; mwb_reg_write = 1'b1; mwb_result = 32'h22;
        exp_q.push_back(exp_vec(32'hAA, 32'hBB, 4'b0010, 4'd1, 5'd9, 1'b0));
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL fwd_x0 got %h exp %h", got_v, exp_v); end
        exm_rd_addr = 5'd5; mwb_rd_addr = 5'd5;
        exp_q.push_back(exp_vec(32'hAA, 32'h11, 4'b0010, 4'd1, 5'd9, 1'b0));
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL fwd_rs2_exm got %h exp %h", got_v, exp_v); end
        idle_inputs();
        step();
    endtask

    task automatic test_imm();
        ex_ready = 1'b1;
        offer(5'd1, 5'd6, 32'h10, 32'h20, 32'hFFFF_FFF0, 1'b1, 4'b0000, 4'd0, 5'd8, 1'b0);
        step();
        exm_rd_addr = 5'd6; exm_reg_write = 1'b1; exm_result = 32'h55;
        offer(5'd1, 5'd6, 32'h10, 32'h20, 32'hFFFF_FFF0, 1'b0, 4'b0000, 4'd0, 5'd8, 1'b0);
        exp_q.push_back(exp_vec(32'h10, 32'hFFFF_FFF0, 4'b0000, 4'd0, 5'd8, 1'b0));
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL imm_select got %h exp %h", got_v, exp_v); end
        exp_q.push_back(exp_vec(32'h10, 32'h55, 4'b0000, 4'd0, 5'd8, 1'b0));
        step();
        id_valid = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL imm_off_fwd got %h exp %h", got_v, exp_v); end
        idle_inputs();
        step();
    endtask

    task automatic test_stall();
        logic [15:0] cnt0;
        cnt0 = 16'd0;
`ifdef ID_EX_STALL_CNT_EN
        cnt0 = stall_cnt;
`endif
        ex_ready = 1'b0;
        offer(5'd0, 5'd9, 32'h1, 32'h1, 32'h77, 1'b0, 4'b0010, 4'd5, 5'd10, 1'b1);
        step();
        // A competing instruction is offered throughout the stall and must be refused.
        offer(5'd0, 5'd9, 32'h5, 32'h5, 32'h0, 1'b0, 4'b0100, 4'd6, 5'd11, 1'b0);
        mwb_rd_addr = 5'd9; mwb_reg_write = 1'b1; mwb_result = 32'h99;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_vec++;
            if (id_ready !== 1'b0) begin n_err++; $display("FAIL stall_id_ready_c%0d got %b exp 0", c, id_ready); end
            exp_q.push_back(exp_vec(32'h1, 32'h99, 4'b0010, 4'd5, 5'd10, 1'b1));
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL stall_hold_c%0d got %h exp %h", c, got_v, exp_v); end
            step();
            mwb_reg_write = 1'b0;
        end
        ex_ready = 1'b1;
        id_valid = 1'b0;
        #1;
        n_vec++;
        if (id_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b exp 1", id_ready); end
        exp_q.push_back(exp_vec(32'h1, 32'h99, 4'b0010, 4'd5, 5'd10, 1'b1));
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL stall_release got %h exp %h", got_v, exp_v); end
`ifdef ID_EX_STALL_CNT_EN
        n_vec++;
        if (stall_cnt - cnt0 !== 16'd3) begin
            n_err++; $display("FAIL stall_cnt_delta got %0d exp 3", stall_cnt - cnt0);
        end
`endif
        step();
        n_vec++;
        if (ex_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b exp 0", ex_valid); end
        idle_inputs();
    endtask

    task automatic test_flush();
        // Flush while holding.
        ex_ready = 1'b0;
        offer(5'd1, 5'd2, 32'h3, 32'h4, 32'h0, 1'b0, 4'b0000, 4'd0, 5'd12, 1'b1);
        step();
        offer(5'd1, 5'd2, 32'h8, 32'h9, 32'h0, 1'b0, 4'b0001, 4'd0, 5'd13, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_err++; $display("FAIL flush_hold got valid=%b rw=%b exp 0/0", ex_valid, ex_reg_write);
        end
        // Flush while accepting: offer is taken but discarded.
        ex_ready = 1'b1;
        offer(5'd1, 5'd2, 32'h8, 32'h9, 32'h0, 1'b0, 4'b0001, 4'd0, 5'd13, 1'b1);
        flush = 1'b1;
        #1;
        n_vec++;
        if (id_ready !== 1'b1) begin n_err++; $display("FAIL flush_id_ready got %b exp 1", id_ready); end
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_err++; $display("FAIL flush_accept got valid=%b rw=%b exp 0/0", ex_valid, ex_reg_write);
        end
        // Asynchronous reset in the middle of a stall.
        ex_ready = 1'b0;
        offer(5'd1, 5'd2, 32'h123, 32'h456, 32'h0, 1'b0, 4'b1111, 4'd9, 5'd3, 1'b1);
        step();
        id_valid = 1'b0;
        step();
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_div_zero !== 1'b0) begin
            n_err++; $display("FAIL async_rst_valid got valid=%b dz=%b exp 0/0", ex_valid, ex_div_zero);
        end
        n_vec++;
        if (got_v !== {VW{1'b0}}) begin n_err++; $display("FAIL async_rst_fields got %h exp 0", got_v); end
`ifdef ID_EX_STALL_CNT_EN
        n_vec++;
        if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL async_rst_stall_cnt got %0d exp 0", stall_cnt); end
`endif
        #1;
        rst = 1'b0;
        ex_ready = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_div_zero();
        logic exp_dz [4];
        exp_dz[0] = 1'b1;
        exp_dz[1] = 1'b1;
        exp_dz[2] = 1'b0;
        exp_dz[3] = 1'b0;
        ex_ready = 1'b1;
        offer(5'd1, 5'd2, 32'h9, 32'h0, 32'h0, 1'b0, 4'b0011, 4'd0, 5'd1, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: offer(5'd1, 5'd2, 32'h9, 32'h0, 32'h0, 1'b0, 4'b1111, 4'd0, 5'd1, 1'b1);
                1: offer(5'd1, 5'd2, 32'h9, 32'h0, 32'h4, 1'b1, 4'b0011, 4'd0, 5'd1, 1'b1);
                2: offer(5'd1, 5'd2, 32'h9, 32'h0, 32'h0, 1'b0, 4'b0000, 4'd0, 5'd1, 1'b1);
                default: id_valid = 1'b0;
            endcase
            #1;
            n_vec++;
            if (ex_valid !== 1'b1 || ex_div_zero !== exp_dz[i]) begin
                n_err++; $display("FAIL div_zero_%0d got valid=%b dz=%b exp 1/%b", i, ex_valid, ex_div_zero, exp_dz[i]);
            end
            step();
        end
        n_vec++;
        if (ex_valid !== 1'b0 || ex_div_zero !== 1'b0) begin
            n_err++; $display("FAIL div_zero_idle got valid=%b dz=%b exp 0/0", ex_valid, ex_div_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic               v;
        logic [RADDR_W-1:0] a1, a2, rd;
        logic [XLEN-1:0]    d1, d2, imm;
        logic               ui, rw;
        logic [3:0]         c, nn;
        ex_ready = 1'b1;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            v   = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            a1  = RADDR_W'($urandom_range(0, 31));
            a2  = RADDR_W'($urandom_range(0, 31));
            rd  = RADDR_W'($urandom_range(0, 31));
            d1  = $urandom;
            d2  = $urandom;
            imm = $urandom;
            ui  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            c   = 4'($urandom_range(0, 15));
            nn  = 4'($urandom_range(0, 15));
            if (v) begin
                offer(a1, a2, d1, d2, imm, ui, c, nn, rd, rw);
                exp_q.push_back(exp_vec(d1, ui ? imm : d2, c, nn, rd, rw));
            end else begin
                id_valid = 1'b0;
            end
            step();
            n_vec++;
            if (ex_valid !== v) begin n_err++; $display("FAIL b2b_valid_%0d got %b exp %b", i, ex_valid, v); end
            if (v) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (got_v !== exp_v) begin n_err++; $display("FAIL b2b_fields_%0d got %h exp %h", i, got_v, exp_v); end
            end
        end
        id_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        ex_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_forward();
        test_imm();
        test_stall();
        test_flush();
        test_div_zero();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
